// File: rtl/imem_load_ctrl_if.sv
// Boot loader bus bundle: program byte stream, imem write port, fetch port and core control.
interface imem_load_ctrl_if #(
  parameter int unsigned MEM_BYTES = 256
);
  localparam int unsigned ADDR_W = $clog2(MEM_BYTES);

  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [31:0]       cpu_pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              cpu_rst_n;
  logic              cpu_stall;
  logic              load_done;
  logic              load_err;
  logic              fetch_fault;

  modport master (
    output load_start, load_len, byte_valid, byte_data, cpu_pc,
    input  byte_ready, mem_we, mem_waddr, mem_wdata, fetch_addr,
           cpu_rst_n, cpu_stall, load_done, load_err, fetch_fault
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data, cpu_pc,
    output byte_ready, mem_we, mem_waddr, mem_wdata, fetch_addr,
           cpu_rst_n, cpu_stall, load_done, load_err, fetch_fault
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot-time instruction memory loader: streams a program into imem, holds the core
// in reset while loading, then releases it and range-checks every fetch PC.
module imem_load_ctrl #(
  parameter int unsigned MEM_BYTES = 256
) (
  input logic             clk,
  input logic             reset,
  imem_load_ctrl_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned SUM_W  = ADDR_W + 2;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERROR} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              fetch_fault_q, fetch_fault_d;
  logic              len_ok_c, pc_bad_c, take_c;

  // A word fetch must lie entirely inside the loaded program image.
  assign len_ok_c = (bus.load_len != '0) &&
                    (bus.load_len <= LEN_W'(MEM_BYTES)) &&
                    (bus.load_len[1:0] == 2'b00);
  assign pc_bad_c = (bus.cpu_pc[1:0] != 2'b00) ||
                    (bus.cpu_pc[31:ADDR_W] != '0) ||
                    ((SUM_W'(bus.cpu_pc[ADDR_W-1:0]) + SUM_W'(3)) >= SUM_W'(len_q));
  assign take_c   = bus.byte_valid && (state_q == LOAD);

  assign bus.byte_ready  = (state_q == LOAD);
  assign bus.fetch_addr  = ((state_q == RUN) && !fetch_fault_q) ? bus.cpu_pc[ADDR_W-1:0] : '0;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_waddr   = mem_waddr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.cpu_rst_n   = cpu_rst_n_q;
  assign bus.cpu_stall   = cpu_stall_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_err    = load_err_q;
  assign bus.fetch_fault = fetch_fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      len_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      cpu_rst_n_q   <= 1'b0;
      cpu_stall_q   <= 1'b1;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      len_q         <= len_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      cpu_stall_q   <= cpu_stall_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Next state and next registered outputs; load_start beats a same-cycle PC fault.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    len_d         = len_q;
    mem_we_d      = 1'b0;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_rst_n_d   = cpu_rst_n_q;
    cpu_stall_d   = cpu_stall_q;
    load_done_d   = load_done_q;
    load_err_d    = load_err_q;
    fetch_fault_d = fetch_fault_q;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (bus.load_start) begin
          cpu_rst_n_d = 1'b0;
          cpu_stall_d = 1'b1;
          load_done_d = 1'b0;
          if (len_ok_c) begin
            state_d       = LOAD;
            len_d         = bus.load_len;
            count_d       = '0;
            load_err_d    = 1'b0;
            fetch_fault_d = 1'b0;
          end else begin
            state_d    = ERROR;
            load_err_d = 1'b1;
          end
        end else if (state_q == RUN) begin
          cpu_rst_n_d   = 1'b1;
          load_done_d   = 1'b1;
          fetch_fault_d = fetch_fault_q | pc_bad_c;
          cpu_stall_d   = fetch_fault_q | pc_bad_c;
        end
      end
      LOAD: begin
        if (take_c) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = count_q[ADDR_W-1:0];
          mem_wdata_d = bus.byte_data;
          count_d     = count_q + LEN_W'(1);
          if (count_q == (len_q - LEN_W'(1))) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a per-cycle behavioural model and literal pins.
module tb_imem_load_ctrl;
  localparam int unsigned MEM_BYTES = 256;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_load_ctrl_if #(.MEM_BYTES(MEM_BYTES)) bus ();
  imem_load_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // model phases: 0 idle, 1 loading, 2 draining, 3 running, 4 error
  int m_ph, m_len, m_left, m_wa, m_wd;
  bit m_we, m_rst, m_stall, m_done, m_err, m_fault;
  int m_mem [256];
  int log_a [$];
  int log_d [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = 0; m_len = 0; m_left = 0; m_we = 0; m_wa = 0; m_wd = 0;
    m_rst = 0; m_stall = 1; m_done = 0; m_err = 0; m_fault = 0;
  endfunction

  function automatic void model_step(input bit ls, input int len, input bit bv,
                                     input int bd, input longint pc);
    bit len_ok = (len != 0) && (len <= 256) && (len % 4 == 0);
    bit pc_ok  = (pc % 4 == 0) && (pc + 4 <= m_len);
    m_we = 0;
    if ((m_ph == 0 || m_ph == 3 || m_ph == 4) && ls) begin
      m_rst = 0; m_stall = 1; m_done = 0;
      if (len_ok) begin
        m_ph = 1; m_len = len; m_left = len; m_err = 0; m_fault = 0;
      end else begin
        m_ph = 4; m_err = 1;
      end
    end else if (m_ph == 3) begin
      m_rst = 1; m_done = 1;
      if (!pc_ok) m_fault = 1;
      m_stall = m_fault;
    end else if (m_ph == 1) begin
      if (bv) begin
        m_we = 1; m_wa = m_len - m_left; m_wd = bd;
        m_mem[m_wa] = bd;
        m_left--;
        if (m_left == 0) m_ph = 2;
      end
    end else if (m_ph == 2) begin
      m_ph = 3;
    end
  endfunction

  // Compare process: one tick after every rising edge, inputs still as sampled.
  initial begin
    model_reset();
    forever begin
      @(posedge clk); #1;
      if (!reset) model_reset();
      else model_step(bus.load_start, int'(bus.load_len), bus.byte_valid,
                      int'(bus.byte_data), longint'(bus.cpu_pc));
      if (bus.mem_we === 1'b1) begin
        log_a.push_back(int'(bus.mem_waddr));
        log_d.push_back(int'(bus.mem_wdata));
      end
      chk("byte_ready",  64'(bus.byte_ready),  64'(m_ph == 1));
      chk("mem_we",      64'(bus.mem_we),      64'(m_we));
      if (m_we) begin
        chk("mem_waddr", 64'(bus.mem_waddr),   64'(m_wa));
        chk("mem_wdata", 64'(bus.mem_wdata),   64'(m_wd));
      end
      chk("cpu_rst_n",   64'(bus.cpu_rst_n),   64'(m_rst));
      chk("cpu_stall",   64'(bus.cpu_stall),   64'(m_stall));
      chk("load_done",   64'(bus.load_done),   64'(m_done));
      chk("load_err",    64'(bus.load_err),    64'(m_err));
      chk("fetch_fault", 64'(bus.fetch_fault), 64'(m_fault));
      chk("fetch_addr",  64'(bus.fetch_addr),
          (m_ph == 3 && !m_fault) ? 64'(bus.cpu_pc % 256) : 64'(0));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int len);
    bus.load_start = 1'b1;
    bus.load_len   = 9'(len);
    cyc();
    bus.load_start = 1'b0;
  endtask

  task automatic feed(input int n, input int first, input int inc);
    for (int i = 0; i < n; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'(first + i * inc);
      cyc();
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  task automatic check_log(input string tag, input int base, input int n,
                           input int first, input int inc);
    chk({tag, "_count"}, 64'(log_a.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < log_a.size()) begin
        chk({tag, "_addr"}, 64'(log_a[base + i]), 64'(i));
        chk({tag, "_data"}, 64'(log_d[base + i]), 64'((first + i * inc) % 256));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"},  64'(bus.byte_ready),  64'(0));
    chk({tag, "_mem_we"},      64'(bus.mem_we),      64'(0));
    chk({tag, "_mem_waddr"},   64'(bus.mem_waddr),   64'(0));
    chk({tag, "_mem_wdata"},   64'(bus.mem_wdata),   64'(0));
    chk({tag, "_cpu_rst_n"},   64'(bus.cpu_rst_n),   64'(0));
    chk({tag, "_cpu_stall"},   64'(bus.cpu_stall),   64'(1));
    chk({tag, "_load_done"},   64'(bus.load_done),   64'(0));
    chk({tag, "_load_err"},    64'(bus.load_err),    64'(0));
    chk({tag, "_fetch_fault"}, 64'(bus.fetch_fault), 64'(0));
    chk({tag, "_fetch_addr"},  64'(bus.fetch_addr),  64'(0));
  endtask

  initial begin
    int base;
    int bad_lens [3] = '{0, 6, 260};
    int dmem [16];
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.cpu_pc     = '0;
    cyc(2);
    chk_reset_vals("por");
    reset = 1'b1;
    cyc(2);

    // normal 8-byte load
    base = log_a.size();
    start(8);
    feed(8, 8'h11, 8'h11);
    chk("t1_done_drain", 64'(bus.load_done), 64'(0));
    cyc();
    chk("t1_done_edge1", 64'(bus.load_done), 64'(0));
    chk("t1_rst_edge1",  64'(bus.cpu_rst_n), 64'(0));
    cyc();
    chk("t1_done_edge2", 64'(bus.load_done), 64'(1));
    chk("t1_rst_edge2",  64'(bus.cpu_rst_n), 64'(1));
    chk("t1_stall",      64'(bus.cpu_stall), 64'(0));
    check_log("t1", base, 8, 8'h11, 8'h11);

    // gapped 4-byte stream, then bytes offered after the load must be ignored
    base = log_a.size();
    start(4);
    for (int i = 0; i < 7; i++) begin
      bus.byte_valid = (i % 2 == 0);
      bus.byte_data  = 8'(8'hA0 + i);
      cyc();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    #1 chk("t2_ready_after", 64'(bus.byte_ready), 64'(0));
    cyc(3);
    bus.byte_valid = 1'b0;
    check_log("t2", base, 4, 8'hA0, 2);

    // rejected lengths from IDLE, last one recovers with a legal length
    foreach (bad_lens[k]) begin
      do_reset();
      base = log_a.size();
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h77;
      start(bad_lens[k]);
      cyc(2);
      bus.byte_valid = 1'b0;
      chk("t3_err",   64'(bus.load_err),    64'(1));
      chk("t3_rst",   64'(bus.cpu_rst_n),   64'(0));
      chk("t3_stall", 64'(bus.cpu_stall),   64'(1));
      chk("t3_nowr",  64'(log_a.size() - base), 64'(0));
    end
    start(4);
    chk("t3_err_clr", 64'(bus.load_err), 64'(0));
    feed(4, 8'h31, 1);
    cyc(3);
    chk("t3_done", 64'(bus.load_done), 64'(1));
    check_log("t3", base, 4, 8'h31, 1);

    // fetch range checks on a 16-byte image
    do_reset();
    start(16);
    feed(16, 8'h40, 1);
    cyc(3);
    bus.cpu_pc = 32'h0C;
    #1 chk("t4_faddr_0c", 64'(bus.fetch_addr), 64'(8'h0C));
    cyc();
    chk("t4_nofault_0c", 64'(bus.fetch_fault), 64'(0));
    chk("t4_nostall_0c", 64'(bus.cpu_stall),   64'(0));
    bus.cpu_pc = 32'h10;
    cyc();
    chk("t4_fault_10", 64'(bus.fetch_fault), 64'(1));
    chk("t4_stall_10", 64'(bus.cpu_stall),   64'(1));
    chk("t4_faddr_10", 64'(bus.fetch_addr),  64'(0));
    bus.cpu_pc = 32'h0;
    start(16);
    chk("t4_fault_clr", 64'(bus.fetch_fault), 64'(0));
    feed(16, 8'h50, 1);
    cyc(3);
    bus.cpu_pc = 32'h02;
    cyc();
    chk("t4_fault_02", 64'(bus.fetch_fault), 64'(1));
    bus.cpu_pc = 32'h0;
    start(16);
    feed(16, 8'h50, 1);
    cyc(3);
    bus.cpu_pc = 32'h100;
    cyc();
    chk("t4_fault_100", 64'(bus.fetch_fault), 64'(1));
    chk("t4_faddr_100", 64'(bus.fetch_addr),  64'(0));

    // reload from RUN in the same cycle as an illegal PC
    bus.cpu_pc = 32'h0;
    start(16);
    feed(16, 8'h60, 1);
    cyc(3);
    base = log_a.size();
    bus.cpu_pc = 32'h10;
    start(4);
    chk("t5_rst",   64'(bus.cpu_rst_n),   64'(0));
    chk("t5_stall", 64'(bus.cpu_stall),   64'(1));
    chk("t5_done",  64'(bus.load_done),   64'(0));
    chk("t5_fault", 64'(bus.fetch_fault), 64'(0));
    bus.cpu_pc = 32'h0;
    feed(4, 8'h5A, 1);
    cyc(3);
    chk("t5_done_again", 64'(bus.load_done), 64'(1));
    check_log("t5", base, 4, 8'h5A, 1);

    // asynchronous reset after 3 of 8 bytes
    start(8);
    base = log_a.size();
    feed(3, 8'h90, 1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h93;
    #2 reset = 1'b0;
    #1 chk_reset_vals("t6");
    cyc(2);
    reset = 1'b1;
    cyc(4);
    chk("t6_nowr",  64'(log_a.size() - base), 64'(3));
    chk("t6_ready", 64'(bus.byte_ready),      64'(0));
    bus.byte_valid = 1'b0;
    base = log_a.size();
    start(4);
    feed(4, 8'hC0, 1);
    cyc(3);
    chk("t6_done", 64'(bus.load_done), 64'(1));
    check_log("t6", base, 4, 8'hC0, 1);

    // memory image implied by the DUT's writes against the model's image
    foreach (dmem[a]) dmem[a] = 0;
    foreach (log_a[i]) if (log_a[i] < 16) dmem[log_a[i]] = log_d[i];
    for (int a = 0; a < 16; a++) chk("mem_image", 64'(dmem[a]), 64'(m_mem[a]));
    chk("model_mem0", 64'(m_mem[0]), 64'(8'hC0));
    chk("model_mem4", 64'(m_mem[4]), 64'(8'h64));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
